// File: rtl/dtw_pkg.sv
// rtl/dtw_pkg.sv - shared types and constants for the DTW run controller
package dtw_pkg;

  localparam int unsigned DTW_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } dtw_state_e;

  // Result sentinels reported when a run ends without a core result.
  localparam logic [DTW_WIDTH-1:0] DTW_MINVAL_NONE = '1;
  localparam logic [31:0]          DTW_POS_NONE    = 32'hFFFF_FFFF;

endpackage

// File: rtl/dtw_watchdog.sv
// rtl/dtw_watchdog.sv - 32-bit run-cycle counter with terminal count
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear counter to 0 (wins over en)
//   en       : increment counter
//   count    : current count
//   tc       : count equals TIMEOUT_CYCLES-1
module dtw_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] count,
  output logic        tc
);

  localparam logic [31:0] TC_VALUE = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == TC_VALUE);

endmodule

// File: rtl/dtw_run_ctrl.sv
// rtl/dtw_run_ctrl.sv - run controller and result collector for dtw_core
//   clk, rst                      : clock, synchronous active-high reset
//   start, abort, threshold       : host run control, threshold latched on start
//   busy                          : high in RUN and HOLD
//   core_rst, core_running        : drive dtw_core
//   core_done, core_minval/position : dtw_core results
//   res_valid/res_ready           : one-result-per-run handshake
//   res_minval/position/hit/timeout/cycles : captured result fields
module dtw_run_ctrl
  import dtw_pkg::*;
#(
  parameter int unsigned WIDTH          = DTW_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] threshold,
  output logic             busy,
  output logic             core_rst,
  output logic             core_running,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_minval,
  input  logic [31:0]      core_position,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_minval,
  output logic [31:0]      res_position,
  output logic             res_hit,
  output logic             res_timeout,
  output logic [31:0]      res_cycles
);

  dtw_state_e       state_q, state_d;
  logic [WIDTH-1:0] thr_q, thr_d;
  logic [WIDTH-1:0] minval_q, minval_d;
  logic [31:0]      position_q, position_d;
  logic             hit_q, hit_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      cycles_q, cycles_d;

  logic        wd_clr;
  logic        wd_en;
  logic [31:0] wd_count;
  logic        wd_tc;

  dtw_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk  (clk),
    .rst  (rst),
    .clr  (wd_clr),
    .en   (wd_en),
    .count(wd_count),
    .tc   (wd_tc)
  );

  always_comb begin
    state_d    = state_q;
    thr_d      = thr_q;
    minval_d   = minval_q;
    position_d = position_q;
    hit_d      = hit_q;
    timeout_d  = timeout_q;
    cycles_d   = cycles_q;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          thr_d   = threshold;
          wd_clr  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        wd_en = 1'b1;
        // Exit priority: abort, then core result, then watchdog.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (core_done) begin
          minval_d   = core_minval;
          position_d = core_position;
          hit_d      = (core_minval < thr_q);
          timeout_d  = 1'b0;
          cycles_d   = wd_count + 32'd1;
          state_d    = ST_HOLD;
        end else if (wd_tc) begin
          minval_d   = {WIDTH{1'b1}};
          position_d = DTW_POS_NONE;
          hit_d      = 1'b0;
          timeout_d  = 1'b1;
          cycles_d   = wd_count + 32'd1;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      thr_q      <= '0;
      minval_q   <= '0;
      position_q <= '0;
      hit_q      <= 1'b0;
      timeout_q  <= 1'b0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      thr_q      <= thr_d;
      minval_q   <= minval_d;
      position_q <= position_d;
      hit_q      <= hit_d;
      timeout_q  <= timeout_d;
      cycles_q   <= cycles_d;
    end
  end

  // rst feeds core_rst directly so the core is cleared on the same edge.
  assign core_rst     = rst || (state_q != ST_RUN);
  assign core_running = !rst && (state_q == ST_RUN);
  assign busy         = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign res_valid    = (state_q == ST_HOLD);
  assign res_minval   = minval_q;
  assign res_position = position_q;
  assign res_hit      = hit_q;
  assign res_timeout  = timeout_q;
  assign res_cycles   = cycles_q;

endmodule

// File: tb/tb_dtw_run_ctrl.sv
// tb/tb_dtw_run_ctrl.sv - directed self-checking bench for dtw_run_ctrl
module tb_dtw_run_ctrl;

  localparam int W  = 16;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  threshold = '0;
  logic          busy;
  logic          core_rst;
  logic          core_running;
  logic          core_done = 1'b0;
  logic [W-1:0]  core_minval = '0;
  logic [31:0]   core_position = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [W-1:0]  res_minval;
  logic [31:0]   res_position;
  logic          res_hit;
  logic          res_timeout;
  logic [31:0]   res_cycles;

  int checks = 0;
  int errors = 0;

  dtw_run_ctrl #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .threshold(threshold),
    .busy(busy), .core_rst(core_rst), .core_running(core_running),
    .core_done(core_done), .core_minval(core_minval), .core_position(core_position),
    .res_valid(res_valid), .res_ready(res_ready), .res_minval(res_minval),
    .res_position(res_position), .res_hit(res_hit), .res_timeout(res_timeout),
    .res_cycles(res_cycles)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_run(input logic [W-1:0] thr);
    threshold = thr;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b expected 1", core_rst); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (core_running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", core_running); end
    checks++; if ({res_minval, res_position, res_hit, res_timeout, res_cycles} !== '0) begin
      errors++; $display("FAIL reset_fields: got %h/%h/%b/%b/%h expected all 0",
                         res_minval, res_position, res_hit, res_timeout, res_cycles);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_normal();
    start_run(16'd500);
    checks++; if (core_running !== 1'b1 || core_rst !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL normal_run_outputs: got running=%b rst=%b busy=%b expected 1/0/1", core_running, core_rst, busy);
    end
    tick(49);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL normal_early_valid: got %b expected 0", res_valid); end
    core_done = 1'b1; core_minval = 16'd320; core_position = 32'd12345;
    tick();
    core_done = 1'b0;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL normal_valid: got %b expected 1", res_valid); end
    checks++; if (res_minval !== 16'd320) begin errors++; $display("FAIL normal_minval: got %0d expected 320", res_minval); end
    checks++; if (res_position !== 32'd12345) begin errors++; $display("FAIL normal_position: got %0d expected 12345", res_position); end
    checks++; if (res_hit !== 1'b1) begin errors++; $display("FAIL normal_hit: got %b expected 1", res_hit); end
    checks++; if (res_timeout !== 1'b0) begin errors++; $display("FAIL normal_timeout: got %b expected 0", res_timeout); end
    checks++; if (res_cycles !== 32'd50) begin errors++; $display("FAIL normal_cycles: got %0d expected 50", res_cycles); end
    checks++; if (core_rst !== 1'b1 || core_running !== 1'b0) begin
      errors++; $display("FAIL normal_hold_core: got rst=%b running=%b expected 1/0", core_rst, core_running);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL normal_handshake: got valid=%b busy=%b expected 0/0", res_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    start_run(16'd10);
    core_done = 1'b1; core_minval = 16'd1; core_position = 32'd2;
    tick();
    core_done = 1'b0;
    checks++; if (res_valid !== 1'b1 || res_cycles !== 32'd1) begin
      errors++; $display("FAIL b2b_first: got valid=%b cycles=%0d expected 1/1", res_valid, res_cycles);
    end
    res_ready = 1'b1; start = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b expected 0", busy); end
    tick();
    start = 1'b0;
    checks++; if (core_running !== 1'b1) begin errors++; $display("FAIL b2b_restart: got %b expected 1", core_running); end
    core_done = 1'b1; core_minval = 16'd20; core_position = 32'd3;
    tick();
    core_done = 1'b0;
    checks++; if (res_valid !== 1'b1 || res_hit !== 1'b0 || res_cycles !== 32'd1) begin
      errors++; $display("FAIL b2b_second: got valid=%b hit=%b cycles=%0d expected 1/0/1", res_valid, res_hit, res_cycles);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_miss_backpressure();
    int bad = 0;
    start_run(16'd500);
    tick(4);
    core_done = 1'b1; core_minval = 16'd500; core_position = 32'd777;
    tick();
    core_done = 1'b0; core_minval = 16'd3; core_position = 32'd4;
    checks++; if (res_hit !== 1'b0) begin errors++; $display("FAIL miss_hit: got %b expected 0", res_hit); end
    start = 1'b1; abort = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_minval !== 16'd500 || res_position !== 32'd777 || res_cycles !== 32'd5) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL bp_stable[%0d]: got valid=%b minval=%0d pos=%0d cycles=%0d expected 1/500/777/5",
                               i, res_valid, res_minval, res_position, res_cycles);
      end
      tick();
    end
    start = 1'b0; abort = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release: got valid=%b busy=%b expected 0/0", res_valid, busy);
    end
    checks++; if (res_minval !== 16'd500 || res_position !== 32'd777) begin
      errors++; $display("FAIL bp_retained: got minval=%0d pos=%0d expected 500/777", res_minval, res_position);
    end
  endtask

  task automatic test_timeout();
    start_run(16'hFFFF);
    tick(TO - 1);
    checks++; if (res_valid !== 1'b0 || core_running !== 1'b1) begin
      errors++; $display("FAIL to_last_run: got valid=%b running=%b expected 0/1", res_valid, core_running);
    end
    tick();
    chk("to_valid", {31'd0, res_valid}, 32'd1);
    chk("to_timeout", {31'd0, res_timeout}, 32'd1);
    chk("to_minval", {16'd0, res_minval}, 32'h0000FFFF);
    chk("to_position", res_position, 32'hFFFFFFFF);
    chk("to_cycles", res_cycles, 32'd100);
    chk("to_hit", {31'd0, res_hit}, 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_abort_done();
    core_done = 1'b1; core_minval = 16'd5; core_position = 32'd6;
    tick();
    chk("idle_done_ignored", {31'd0, res_valid}, 32'd0);
    core_done = 1'b0;
    start_run(16'd100);
    tick(3);
    abort = 1'b1; core_done = 1'b1;
    tick();
    abort = 1'b0; core_done = 1'b0;
    chk("abort_valid", {31'd0, res_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_core_rst", {31'd0, core_rst}, 32'd1);
    chk("abort_fields_kept", {res_timeout, res_cycles[30:0]}, {1'b1, 31'd100});
    tick(2);
    chk("abort_no_late_valid", {31'd0, res_valid}, 32'd0);
  endtask

  task automatic test_done_on_timeout();
    start_run(16'd100);
    tick(TO - 1);
    core_done = 1'b1; core_minval = 16'd77; core_position = 32'd42;
    tick();
    core_done = 1'b0;
    chk("dto_valid", {31'd0, res_valid}, 32'd1);
    chk("dto_timeout", {31'd0, res_timeout}, 32'd0);
    chk("dto_minval", {16'd0, res_minval}, 32'd77);
    chk("dto_position", res_position, 32'd42);
    chk("dto_hit", {31'd0, res_hit}, 32'd1);
    chk("dto_cycles", res_cycles, 32'd100);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    start_run(16'd10);
    tick(29);
    rst = 1'b1;
    #1;
    chk("mid_rst_core_rst_same", {31'd0, core_rst}, 32'd1);
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_core_rst", {31'd0, core_rst}, 32'd1);
    chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
    chk("mid_rst_fields", {res_minval, res_position[15:0]} | {16'd0, res_cycles[15:0]} | {31'd0, res_hit | res_timeout}, 32'd0);
    tick();
    start_run(16'd10);
    tick(9);
    core_done = 1'b1; core_minval = 16'd9; core_position = 32'd99;
    tick();
    core_done = 1'b0;
    chk("post_rst_valid", {31'd0, res_valid}, 32'd1);
    chk("post_rst_hit", {31'd0, res_hit}, 32'd1);
    chk("post_rst_cycles", res_cycles, 32'd10);
    chk("post_rst_position", res_position, 32'd99);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_back_to_back();
    test_miss_backpressure();
    test_timeout();
    test_abort_done();
    test_done_on_timeout();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
